// File: rtl/counter_seq_ctrl.sv
// ---------------------------------------------------------------------------
// counter_seq_ctrl
//
// Sequencer for an external up-counter with enable and synchronous clear.
// Runs one-shot or periodic count intervals up to a programmable terminal
// value, with pause, abort, a repeat count and tick/done/err event pulses.
//
// Counter contract assumed: on each clk edge the counter loads 0 when cnt_clr
// is high, else increments when cnt_en is high, else holds.
//
// Ports:
//   clk        rising-edge clock
//   reset      asynchronous, active-high reset
//   start      start request, sampled only while idle
//   abort      cancel the current operation
//   pause      level; freezes counting while high
//   periodic   mode sampled at start (0 = one-shot, 1 = periodic)
//   term_val   terminal count sampled at start; 0 is rejected with err
//   reps       periods to run in periodic mode, sampled at start; 0 = forever
//   cnt_val    current counter value
//   cnt_en     counter increment enable
//   cnt_clr    counter synchronous clear (wins over cnt_en at the counter)
//   busy       high whenever not idle
//   paused     counting phase with pause high and no abort
//   tick       one-cycle pulse when the terminal count is reached
//   done       one-cycle pulse when the operation completes normally
//   err        one-cycle pulse when start arrives with term_val == 0
//   reps_left  remaining periods
//
// Handshake: start is a single-cycle request accepted in the idle cycle it is
// seen; there is no ready back-pressure, a start while busy is simply dropped.
// ---------------------------------------------------------------------------
module counter_seq_ctrl #(
   parameter int WIDTH  = 4,
   parameter int REPS_W = 4
) (
   input  logic              clk,
   input  logic              reset,
   input  logic              start,
   input  logic              abort,
   input  logic              pause,
   input  logic              periodic,
   input  logic [WIDTH-1:0]  term_val,
   input  logic [REPS_W-1:0] reps,
   input  logic [WIDTH-1:0]  cnt_val,
   output logic              cnt_en,
   output logic              cnt_clr,
   output logic              busy,
   output logic              paused,
   output logic              tick,
   output logic              done,
   output logic              err,
   output logic [REPS_W-1:0] reps_left
);

   localparam logic [1:0] S_IDLE  = 2'd0;
   localparam logic [1:0] S_CLEAR = 2'd1;
   localparam logic [1:0] S_RUN   = 2'd2;
   localparam logic [1:0] S_DONE  = 2'd3;

   logic [1:0]        state;
   logic [1:0]        state_nxt;
   logic [WIDTH-1:0]  term_q;
   logic              periodic_q;
   logic              reps_inf_q;
   logic [REPS_W-1:0] reps_left_nxt;
   logic              load;
   logic              hit;

   assign busy   = (state != S_IDLE);
   assign paused = (state == S_RUN) && pause && !abort;

   always_comb begin
      state_nxt     = state;
      reps_left_nxt = reps_left;
      load          = 1'b0;
      cnt_en        = 1'b0;
      cnt_clr       = 1'b0;
      tick          = 1'b0;
      done          = 1'b0;
      err           = 1'b0;
      hit           = (cnt_val == term_q) && !pause;

      case (state)
         S_IDLE: begin
            // err is combinational from start, so it is gated by reset to keep
            // every output low while reset is held.
            if (start && !reset) begin
               if (term_val == '0) begin
                  err = 1'b1;
               end else begin
                  load          = 1'b1;
                  reps_left_nxt = reps;
                  state_nxt     = S_CLEAR;
               end
            end
         end

         S_CLEAR: begin
            cnt_clr = 1'b1;
            if (abort) begin
               state_nxt     = S_IDLE;
               reps_left_nxt = '0;
            end else begin
               state_nxt = S_RUN;
            end
         end

         S_RUN: begin
            if (abort) begin
               cnt_clr       = 1'b1;
               state_nxt     = S_IDLE;
               reps_left_nxt = '0;
            end else if (pause) begin
               // hold: neither enable nor clear, terminal hit suppressed
            end else if (hit) begin
               tick = 1'b1;
               if (periodic_q && (reps_inf_q || (reps_left > REPS_W'(1)))) begin
                  // restart the next period straight from the terminal value
                  cnt_clr = 1'b1;
                  if (!reps_inf_q) begin
                     reps_left_nxt = reps_left - REPS_W'(1);
                  end
               end else begin
                  state_nxt = S_DONE;
                  if (periodic_q) begin
                     reps_left_nxt = '0;
                  end
               end
            end else begin
               cnt_en = 1'b1;
            end
         end

         S_DONE: begin
            if (abort) begin
               cnt_clr = 1'b1;
            end else begin
               done = 1'b1;
            end
            state_nxt     = S_IDLE;
            reps_left_nxt = '0;
         end

         default: begin
            state_nxt = S_IDLE;
         end
      endcase
   end

   // reps_left is cleared whenever the sequencer returns to idle so that all
   // outputs read zero there, including after a one-shot run.
   always_ff @(posedge clk or posedge reset) begin
      if (reset) begin
         state      <= S_IDLE;
         term_q     <= '0;
         periodic_q <= 1'b0;
         reps_inf_q <= 1'b0;
         reps_left  <= '0;
      end else begin
         state     <= state_nxt;
         reps_left <= reps_left_nxt;
         if (load) begin
            term_q     <= term_val;
            periodic_q <= periodic;
            reps_inf_q <= (reps == '0);
         end
      end
   end

endmodule

// File: tb/tb_counter_seq_ctrl.sv
// ---------------------------------------------------------------------------
// tb_counter_seq_ctrl
//
// Drives counter_seq_ctrl together with a behavioural up-counter, keeps an
// operation-level reference of what the sequencer must do, compares every
// output on every falling edge, and checks hand-computed tick/done cycles.
// ---------------------------------------------------------------------------
module tb_counter_seq_ctrl;

   logic       clk      = 1'b0;
   logic       reset    = 1'b0;
   logic       start    = 1'b0;
   logic       abort    = 1'b0;
   logic       pause    = 1'b0;
   logic       periodic = 1'b0;
   logic [3:0] term_val = 4'd0;
   logic [3:0] reps     = 4'd0;
   logic [3:0] cnt_val  = 4'd0;
   logic       cnt_en;
   logic       cnt_clr;
   logic       busy;
   logic       paused;
   logic       tick;
   logic       done;
   logic       err;
   logic [3:0] reps_left;

   int n_chk  = 0;
   int n_fail = 0;
   int cyc    = 0;
   int t0     = 0;

   logic [31:0] exp_q[$];
   logic [31:0] tick_obs[$];
   logic [31:0] done_obs[$];

   counter_seq_ctrl #(.WIDTH(4), .REPS_W(4)) dut (
      .clk       (clk),
      .reset     (reset),
      .start     (start),
      .abort     (abort),
      .pause     (pause),
      .periodic  (periodic),
      .term_val  (term_val),
      .reps      (reps),
      .cnt_val   (cnt_val),
      .cnt_en    (cnt_en),
      .cnt_clr   (cnt_clr),
      .busy      (busy),
      .paused    (paused),
      .tick      (tick),
      .done      (done),
      .err       (err),
      .reps_left (reps_left)
   );

   // ---------------- clock / reset / counter ----------------
   always #5 clk = ~clk;

   always @(posedge clk) cyc <= cyc + 1;

   always @(posedge clk) begin
      if (cnt_clr)     cnt_val <= 4'd0;
      else if (cnt_en) cnt_val <= cnt_val + 4'd1;
   end

   task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
      n_chk++;
      if (act !== exp) begin
         n_fail++;
         $display("FAIL %s: got %0d, expected %0d (cycle %0d)", name, act, exp, cyc - t0);
      end
   endtask

   // ---------------- reference model ----------------
   // An operation is either inactive, in its one clearing cycle, counting
   // towards the terminal value, or in its one completion cycle.
   bit m_busy  = 0;
   bit m_first = 0;
   bit m_fin   = 0;
   bit m_per   = 0;
   bit m_inf   = 0;
   int m_term  = 0;
   int m_left  = 0;
   int m_cnt   = 0;

   logic e_en, e_clr, e_busy, e_paused, e_tick, e_done, e_err;
   int   e_left;

   always @(negedge clk) begin
      e_en = 0; e_clr = 0; e_busy = 0; e_paused = 0;
      e_tick = 0; e_done = 0; e_err = 0;
      e_left = m_left;
      if (reset) begin
         m_busy = 0; m_first = 0; m_fin = 0; m_left = 0; e_left = 0;
      end else if (!m_busy) begin
         if (start && term_val == 4'd0) begin
            e_err = 1;
         end else if (start) begin
            m_busy = 1; m_first = 1;
            m_term = int'(term_val); m_per = periodic;
            m_inf = (reps == 4'd0); m_left = int'(reps);
         end
      end else begin
         e_busy = 1;
         if (m_first) begin
            e_clr = 1; m_first = 0;
            if (abort) begin m_busy = 0; m_left = 0; end
         end else if (m_fin) begin
            if (abort) e_clr = 1; else e_done = 1;
            m_busy = 0; m_fin = 0; m_left = 0;
         end else if (abort) begin
            e_clr = 1; m_busy = 0; m_left = 0;
         end else if (pause) begin
            e_paused = 1;
         end else if (m_cnt == m_term) begin
            e_tick = 1;
            if (m_per && (m_inf || m_left > 1)) begin
               e_clr = 1;
               if (!m_inf) m_left = m_left - 1;
            end else begin
               m_fin = 1;
               if (m_per) m_left = 0;
            end
         end else begin
            e_en = 1;
         end
      end

      chk("cnt_val",   cnt_val,   m_cnt);
      chk("cnt_en",    cnt_en,    e_en);
      chk("cnt_clr",   cnt_clr,   e_clr);
      chk("busy",      busy,      e_busy);
      chk("paused",    paused,    e_paused);
      chk("tick",      tick,      e_tick);
      chk("done",      done,      e_done);
      chk("err",       err,       e_err);
      chk("reps_left", reps_left, e_left);

      if (tick === 1'b1) tick_obs.push_back(cyc - t0);
      if (done === 1'b1) done_obs.push_back(cyc - t0);

      if (e_clr)     m_cnt = 0;
      else if (e_en) m_cnt = (m_cnt + 1) % 16;
   end

   // ---------------- driver tasks ----------------
   task automatic step(input int n);
      repeat (n) begin
         @(posedge clk);
         #1;
      end
   endtask

   task automatic wait_to(input int k);
      int guard = 0;
      while ((cyc - t0) < k && guard < 200) begin
         step(1);
         guard++;
      end
   endtask

   // Pulse start for one cycle; the start cycle is cycle 0 of the run.
   task automatic go(input logic per, input logic [3:0] tv, input logic [3:0] rp);
      tick_obs.delete();
      done_obs.delete();
      @(posedge clk);
      #1;
      start = 1; periodic = per; term_val = tv; reps = rp;
      t0 = cyc;
      step(1);
      start = 0; periodic = ~per; term_val = 4'hA; reps = 4'h7;
   endtask

   task automatic wait_idle(input int budget);
      int n = 0;
      while (busy && n < budget) begin
         step(1);
         n++;
      end
      chk("idle_within_budget", busy, 0);
   endtask

   task automatic check_q(input string name, input logic [31:0] obs[$]);
      chk({name, "_count"}, obs.size(), exp_q.size());
      for (int i = 0; i < obs.size() && i < exp_q.size(); i++)
         chk(name, obs[i], exp_q[i]);
      exp_q.delete();
   endtask

   task automatic check_zero_outputs(input string name);
      chk({name, "_cnt_en"},    cnt_en,    0);
      chk({name, "_cnt_clr"},   cnt_clr,   0);
      chk({name, "_busy"},      busy,      0);
      chk({name, "_paused"},    paused,    0);
      chk({name, "_tick"},      tick,      0);
      chk({name, "_done"},      done,      0);
      chk({name, "_err"},       err,       0);
      chk({name, "_reps_left"}, reps_left, 0);
   endtask

   // ---------------- stimulus ----------------
   initial begin
      #1 reset = 1;
      step(3);
      check_zero_outputs("reset_hold");
      reset = 0;
      step(2);

      // one-shot, term 5
      go(0, 4'd5, 4'd0);
      wait_to(9);
      chk("oneshot_busy_c9", busy, 0);
      chk("oneshot_final_cnt", cnt_val, 5);
      exp_q.push_back(7);  check_q("oneshot_tick", tick_obs);
      exp_q.push_back(8);  check_q("oneshot_done", done_obs);

      // periodic, term 3, reps 2
      go(1, 4'd3, 4'd2);
      wait_to(2);
      chk("per_reps_c2", reps_left, 2);
      wait_to(5);
      chk("per_tick_c5", tick, 1);
      chk("per_clr_c5", cnt_clr, 1);
      wait_to(6);
      chk("per_reps_c6", reps_left, 1);
      wait_to(10);
      chk("per_done_c10", done, 1);
      chk("per_reps_c10", reps_left, 0);
      wait_to(11);
      chk("per_busy_c11", busy, 0);
      chk("per_final_cnt", cnt_val, 3);
      exp_q.push_back(5); exp_q.push_back(9); check_q("per_tick", tick_obs);
      exp_q.push_back(10); check_q("per_done", done_obs);

      // periodic forever, term 2, then abort
      go(1, 4'd2, 4'd0);
      wait_to(68);
      abort = 1;
      #1;
      chk("inf_abort_clr", cnt_clr, 1);
      chk("inf_abort_busy", busy, 1);
      step(1);
      abort = 0;
      chk("inf_idle_after_abort", busy, 0);
      step(2);
      for (int i = 0; i < 22; i++) exp_q.push_back(4 + 3 * i);
      check_q("inf_tick", tick_obs);
      check_q("inf_done", done_obs);

      // pause while cnt_val == 2 for three cycles
      go(0, 4'd5, 4'd0);
      wait_to(4);
      chk("pause_cnt_c4", cnt_val, 2);
      pause = 1;
      #1;
      chk("pause_paused", paused, 1);
      chk("pause_en", cnt_en, 0);
      wait_to(7);
      chk("pause_cnt_held", cnt_val, 2);
      pause = 0;
      wait_idle(30);
      exp_q.push_back(10); check_q("pause_tick", tick_obs);
      exp_q.push_back(11); check_q("pause_done", done_obs);

      // pause held at the terminal value
      go(0, 4'd5, 4'd0);
      wait_to(7);
      chk("tpause_cnt_c7", cnt_val, 5);
      pause = 1;
      #1;
      chk("tpause_no_tick", tick, 0);
      chk("tpause_paused", paused, 1);
      wait_to(9);
      pause = 0;
      #1;
      chk("tpause_tick_c9", tick, 1);
      wait_idle(30);
      exp_q.push_back(9);  check_q("tpause_tick", tick_obs);
      exp_q.push_back(10); check_q("tpause_done", done_obs);

      // start with term_val == 0
      @(posedge clk);
      #1;
      start = 1; term_val = 4'd0; t0 = cyc;
      #1;
      chk("err_pulse", err, 1);
      chk("err_busy", busy, 0);
      step(1);
      start = 0;
      #1;
      chk("err_cleared", err, 0);
      chk("err_still_idle", busy, 0);

      // start while busy is ignored, all-ones terminal not involved
      go(0, 4'd3, 4'd0);
      wait_to(3);
      start = 1; term_val = 4'd9; periodic = 1;
      step(1);
      start = 0;
      wait_idle(30);
      exp_q.push_back(5); check_q("busy_start_tick", tick_obs);
      exp_q.push_back(6); check_q("busy_start_done", done_obs);

      // abort in CLEAR
      go(0, 4'd5, 4'd0);
      abort = 1;
      #1;
      chk("clr_abort_clr", cnt_clr, 1);
      step(1);
      abort = 0;
      chk("clr_abort_idle", busy, 0);
      step(3);
      check_q("clr_abort_tick", tick_obs);
      check_q("clr_abort_done", done_obs);

      // all-ones terminal value
      go(0, 4'd15, 4'd0);
      wait_idle(40);
      chk("max_final_cnt", cnt_val, 15);
      exp_q.push_back(17); check_q("max_tick", tick_obs);
      exp_q.push_back(18); check_q("max_done", done_obs);

      // asynchronous reset in the middle of counting
      go(0, 4'd5, 4'd0);
      wait_to(4);
      #2;
      reset = 1;
      #1;
      check_zero_outputs("async_reset");
      step(2);
      reset = 0;
      check_q("reset_run_tick", tick_obs);
      go(0, 4'd5, 4'd0);
      wait_idle(30);
      exp_q.push_back(7); check_q("after_reset_tick", tick_obs);
      exp_q.push_back(8); check_q("after_reset_done", done_obs);

      step(2);
      $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
      $finish;
   end

   initial begin
      #100000;
      n_fail++;
      $display("FAIL global_timeout: simulation did not complete in time");
      $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
      $finish;
   end

endmodule

// File: doc/counter_seq_ctrl.md
Name: counter_seq_ctrl

Overview:
- Sequencer for an up-counter datapath with enable and synchronous clear. Drives the counter's cnt_en/cnt_clr and watches its value.
- Runs one-shot or periodic count intervals up to a programmable terminal value, with pause, abort, repeat count, and tick/done events.
- Sits between the control/CSR logic and the counter instance.

Parameters:
- WIDTH, 4, counter width; term_val and cnt_val width.
- REPS_W, 4, width of the repeat-count field.

Ports:
- clk  in  1  rising-edge clock
- reset  in  1  asynchronous, active-high reset
- start  in  1  start request; sampled only in IDLE
- abort  in  1  cancel current operation
- pause  in  1  level; freezes counting while high
- periodic  in  1  mode sampled at start: 0 = one-shot, 1 = periodic
- term_val  in  WIDTH  terminal count, sampled at start; 0 is illegal
- reps  in  REPS_W  periods to run in periodic mode, sampled at start; 0 = run forever
- cnt_val  in  WIDTH  current counter value
- cnt_en  out  1  counter increment enable
- cnt_clr  out  1  counter synchronous clear; priority over cnt_en at the counter
- busy  out  1  high in any state other than IDLE
- paused  out  1  RUN & pause & !abort
- tick  out  1  one-cycle pulse when the terminal count is reached
- done  out  1  one-cycle pulse when the operation completes normally
- err  out  1  one-cycle pulse when start arrives with term_val==0
- reps_left  out  REPS_W  remaining periods

Behaviour:
- Counter contract: on each clk edge, next cnt_val = 0 if cnt_clr, else +1 if cnt_en, else hold.
- Registered state: FSM state, term_q, periodic_q, reps_inf_q, reps_left.
- All other outputs decode combinationally from the registered state and current inputs.
- Reset (async, asserted at any time, including mid-RUN): state=IDLE, term_q=0, periodic_q=0, reps_inf_q=0, reps_left=0.
  - All outputs go low immediately, without waiting for a clock.
- FSM states: IDLE, CLEAR, RUN, DONE.
- IDLE:
  - All outputs low.
  - start & term_val!=0: latch term_q, periodic_q, reps_left=reps, and reps_inf_q=(reps==0); go to CLEAR.
  - start & term_val==0: err=1 for that cycle; stay IDLE; no register changes.
- CLEAR: cnt_clr=1, cnt_en=0; go to RUN on the next edge.
- RUN: hit = (cnt_val==term_q) & !pause. Priority order, highest first:
  1. abort: cnt_clr=1, cnt_en=0; go to IDLE; no tick, no done.
  2. pause: cnt_en=0, cnt_clr=0; stay in RUN; count holds; hit suppressed.
  3. hit & !periodic_q: tick=1, cnt_en=0; go to DONE.
  4. hit & periodic_q & (reps_inf_q | reps_left>1): tick=1, cnt_clr=1; stay in RUN; decrement reps_left unless reps_inf_q.
  5. hit & periodic_q & !reps_inf_q & reps_left==1: tick=1, cnt_en=0; reps_left becomes 0; go to DONE.
  6. otherwise: cnt_en=1.
- DONE: done=1, cnt_en=0, cnt_clr=0; go to IDLE. The counter keeps its final value term_q.
- abort in CLEAR or DONE: go to IDLE next edge with cnt_clr=1 that cycle; done is suppressed in DONE.
- Timing: one-shot with no pause runs start -> done in term_q+3 edges. Periodic ticks are spaced term_q+1 cycles apart.
- Wrap-around: cnt_en is never asserted with cnt_val==term_q, so the counter never wraps. term_q of all-ones (15) is legal.
- Inputs are sampled only where stated; start/term_val/reps changes during busy are ignored.
- The freeze on term_q, periodic_q and reps also holds when pause is high.

Test Plan:
- Reset mid-RUN: one-shot term=5; assert reset asynchronously during RUN.
  - All outputs low before the next edge; state IDLE.
  - A subsequent start then works normally.
- One-shot, term_val=5, pulse start in cycle 0.
  - CLEAR in cycle 1; RUN in cycles 2-7 with cnt_val 0..5; tick in cycle 7; done in cycle 8; busy low in cycle 9.
  - Final cnt_val=5; cnt_en never high while cnt_val==5.
- Periodic, term_val=3, reps=2.
  - Ticks exactly 4 cycles apart; cnt_clr high with the first tick; reps_left goes 2->1->0.
  - Exactly two ticks, then done; cnt_val ends at 3.
- Periodic, reps=0, term_val=2.
  - Ticks every 3 cycles for 20+ periods with no done.
  - abort -> IDLE next edge; cnt_clr high that cycle; no done.
- Pause: one-shot term=5; hold pause for 3 cycles while cnt_val=2.
  - paused=1 and cnt_en=0 during the hold; cnt_val stays 2.
  - tick is delayed by exactly 3 cycles (cycle 10).
  - Pause held while cnt_val==5 suppresses tick until pause drops.
- Error and busy cases:
  - start with term_val=0 -> err=1 for one cycle; busy stays 0.
  - start during busy is ignored.
  - abort in CLEAR -> IDLE; done never asserted.
